// File: rtl/reg_writeback_arbiter.sv
// Integer register-file write front end: one result FIFO per source (ALU, LSU)
// feeding a single registered write port through a round-robin arbiter.

module reg_writeback_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic [ADDR_W-1:0]       i_addr,
   input  logic [DATA_W-1:0]       i_data,
   input  logic                    i_pop,
   output logic                    o_ready,
   output logic                    o_nonempty,
   output logic [ADDR_W-1:0]       o_head_addr,
   output logic [DATA_W-1:0]       o_head_data,
   output logic [$clog2(DEPTH):0]  o_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + DATA_W;

   logic [ENT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Ready looks only at occupancy, so a full FIFO refuses a push even while it is popping.
   assign o_ready    = (r_count != CNT_W'(DEPTH));
   assign o_nonempty = (r_count != {CNT_W{1'b0}});
   assign w_push_ok  = i_push && o_ready;
   assign w_pop_ok   = i_pop && o_nonempty;
   assign {o_head_addr, o_head_data} = r_mem[r_rptr];
   assign o_count    = r_count;

   // Entry storage, written on an accepted push; no reset needed on the data path
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= {i_addr, i_data};
      end
   end

   // Pointers wrap naturally at a power-of-two depth; the count separates full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= {PTR_W{1'b0}};
         r_rptr  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + PTR_W'(1'b1);
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + PTR_W'(1'b1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1'b1);
            2'b01:   r_count <= r_count - CNT_W'(1'b1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module reg_writeback_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic [2:0]        pending
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   grant_e            r_last_grant;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;

   logic              w_alu_nonempty;
   logic              w_lsu_nonempty;
   logic [ADDR_W-1:0] w_alu_head_addr;
   logic [DATA_W-1:0] w_alu_head_data;
   logic [ADDR_W-1:0] w_lsu_head_addr;
   logic [DATA_W-1:0] w_lsu_head_data;
   logic [CNT_W-1:0]  w_alu_count;
   logic [CNT_W-1:0]  w_lsu_count;
   logic              w_grant_alu;
   logic              w_grant_lsu;

   function automatic logic [2:0] sat_pending(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      logic [CNT_W:0] total;
      total = {1'b0, a} + {1'b0, b};
      if (total > (CNT_W+1)'(3'd7)) begin
         return 3'd7;
      end else begin
         return total[2:0];
      end
   endfunction

   reg_writeback_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_alu_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (alu_valid),
      .i_addr      (alu_addr),
      .i_data      (alu_data),
      .i_pop       (w_grant_alu),
      .o_ready     (alu_ready),
      .o_nonempty  (w_alu_nonempty),
      .o_head_addr (w_alu_head_addr),
      .o_head_data (w_alu_head_data),
      .o_count     (w_alu_count)
   );

   reg_writeback_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_lsu_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (lsu_valid),
      .i_addr      (lsu_addr),
      .i_data      (lsu_data),
      .i_pop       (w_grant_lsu),
      .o_ready     (lsu_ready),
      .o_nonempty  (w_lsu_nonempty),
      .o_head_addr (w_lsu_head_addr),
      .o_head_data (w_lsu_head_data),
      .o_count     (w_lsu_count)
   );

   // Round-robin grant: contention goes to the source that did not win last time
   always_comb begin
      w_grant_alu = 1'b0;
      w_grant_lsu = 1'b0;
      if (!rdy) begin
         w_grant_alu = 1'b0;
         w_grant_lsu = 1'b0;
      end else if (w_alu_nonempty && w_lsu_nonempty) begin
         if (r_last_grant == GRANT_LSU) begin
            w_grant_alu = 1'b1;
         end else begin
            w_grant_lsu = 1'b1;
         end
      end else if (w_alu_nonempty) begin
         w_grant_alu = 1'b1;
      end else if (w_lsu_nonempty) begin
         w_grant_lsu = 1'b1;
      end else begin
         w_grant_alu = 1'b0;
         w_grant_lsu = 1'b0;
      end
   end

   // Write port: an x0 entry still consumes its grant slot but never raises we
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we         <= 1'b0;
         r_waddr      <= {ADDR_W{1'b0}};
         r_wdata      <= {DATA_W{1'b0}};
         r_last_grant <= GRANT_LSU;
      end else if (w_grant_alu) begin
         r_we         <= (w_alu_head_addr != {ADDR_W{1'b0}});
         r_waddr      <= w_alu_head_addr;
         r_wdata      <= w_alu_head_data;
         r_last_grant <= GRANT_ALU;
      end else if (w_grant_lsu) begin
         r_we         <= (w_lsu_head_addr != {ADDR_W{1'b0}});
         r_waddr      <= w_lsu_head_addr;
         r_wdata      <= w_lsu_head_data;
         r_last_grant <= GRANT_LSU;
      end else begin
         r_we         <= 1'b0;
      end
   end

   assign we      = r_we;
   assign waddr   = r_waddr;
   assign wdata   = r_wdata;
   assign pending = sat_pending(w_alu_count, w_lsu_count);
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: queue-based model checked every cycle,
// plus literal expectations for each scenario.

module tb_reg_writeback_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              rdy;
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              lsu_valid;
   logic              lsu_ready;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_data;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [2:0]        pending;

   always #5 clk = ~clk;

   reg_writeback_arbiter #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_addr  (lsu_addr),
      .lsu_data  (lsu_data),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .pending   (pending)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Behavioural model: two queues and a "who won last" flag
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              q_alu[$];
   ent_t              q_lsu[$];
   bit                m_last_lsu = 1'b1;
   bit                m_live     = 1'b0;
   bit                m_we       = 1'b0;
   logic [ADDR_W-1:0] m_waddr    = '0;
   logic [DATA_W-1:0] m_wdata    = '0;

   task automatic model_step();
      ent_t e;
      bit   pa, pl, ga, gl;
      if (rst) begin
         q_alu.delete();
         q_lsu.delete();
         m_last_lsu = 1'b1;
         m_we       = 1'b0;
         m_waddr    = '0;
         m_wdata    = '0;
         m_live     = 1'b1;
      end else begin
         pa = alu_valid && (q_alu.size() < DEPTH);
         pl = lsu_valid && (q_lsu.size() < DEPTH);
         ga = 1'b0;
         gl = 1'b0;
         if (rdy) begin
            if (q_alu.size() > 0 && q_lsu.size() > 0) begin
               ga = m_last_lsu;
               gl = !m_last_lsu;
            end else begin
               ga = (q_alu.size() > 0);
               gl = (q_lsu.size() > 0);
            end
         end
         if (ga) begin
            e = q_alu.pop_front();
            m_we = (e.addr != 0); m_waddr = e.addr; m_wdata = e.data; m_last_lsu = 1'b0;
         end else if (gl) begin
            e = q_lsu.pop_front();
            m_we = (e.addr != 0); m_waddr = e.addr; m_wdata = e.data; m_last_lsu = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         if (pa) begin
            e.addr = alu_addr; e.data = alu_data; q_alu.push_back(e);
         end
         if (pl) begin
            e.addr = lsu_addr; e.data = lsu_data; q_lsu.push_back(e);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison against the model, away from the active edge
   initial forever begin
      int s;
      @(negedge clk);
      if (m_live) begin
         s = q_alu.size() + q_lsu.size();
         check("cyc_we",        64'(we),        64'(m_we));
         check("cyc_waddr",     64'(waddr),     64'(m_waddr));
         check("cyc_wdata",     64'(wdata),     64'(m_wdata));
         check("cyc_alu_ready", 64'(alu_ready), 64'(q_alu.size() < DEPTH));
         check("cyc_lsu_ready", 64'(lsu_ready), 64'(q_lsu.size() < DEPTH));
         check("cyc_pending",   64'(pending),   64'((s > 7) ? 7 : s));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      logic [ADDR_W-1:0] wseq[$];
      int n_writes;
      rst = 1'b1; rdy = 1'b1;
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
      step(); step();
      check("rst_we", 64'(we), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_waddr", 64'(waddr), 64'd0);
      rst = 1'b0;

      // 1: single ALU write, one-edge pop latency
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
      step();
      alu_valid = 1'b0;
      check("s1_pending_after_push", 64'(pending), 64'd1);
      check("s1_we_before_pop", 64'(we), 64'd0);
      step();
      check("s1_we", 64'(we), 64'd1);
      check("s1_waddr", 64'(waddr), 64'd5);
      check("s1_wdata", 64'(wdata), 64'h1234);
      check("s1_pending", 64'(pending), 64'd0);
      step();
      check("s1_we_drop", 64'(we), 64'd0);

      // 2: fresh reset, ALU wins the first tie, then round-robin alternates
      rst = 1'b1; step(); rst = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA;
      lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'hB;
      step();
      alu_addr = 5'd3; alu_data = 32'hC;
      lsu_addr = 5'd4; lsu_data = 32'hD;
      step();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      check("s2_w0_addr", 64'(waddr), 64'd1);
      check("s2_w0_data", 64'(wdata), 64'hA);
      step();
      check("s2_w1_addr", 64'(waddr), 64'd2);
      check("s2_w1_data", 64'(wdata), 64'hB);
      step();
      check("s2_w2_addr", 64'(waddr), 64'd3);
      step();
      check("s2_w3_addr", 64'(waddr), 64'd4);
      check("s2_w3_we", 64'(we), 64'd1);
      step();
      check("s2_idle_we", 64'(we), 64'd0);

      // 3: fill ALU under stall, push refused while full (even on the popping edge)
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_addr = 5'(8 + i); alu_data = 32'h100 + 32'(i);
         step();
      end
      check("s3_full_ready", 64'(alu_ready), 64'd0);
      check("s3_full_pending", 64'(pending), 64'd4);
      check("s3_stall_we", 64'(we), 64'd0);
      alu_addr = 5'd12; alu_data = 32'h1FF;
      step();
      check("s3_full_reject", 64'(pending), 64'd4);
      rdy = 1'b1;
      step();
      alu_valid = 1'b0;
      check("s3_first_we", 64'(we), 64'd1);
      check("s3_first_addr", 64'(waddr), 64'd8);
      check("s3_ready_back", 64'(alu_ready), 64'd1);
      check("s3_pop_push_reject", 64'(pending), 64'd3);
      for (int i = 1; i < 4; i++) begin
         step();
         check("s3_drain_addr", 64'(waddr), 64'(8 + i));
         check("s3_drain_data", 64'(wdata), 64'(32'h100 + 32'(i)));
      end
      step();
      check("s3_done_we", 64'(we), 64'd0);
      check("s3_done_pending", 64'(pending), 64'd0);

      // 4: x0 entry is popped without a write
      alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF;
      step();
      alu_valid = 1'b0;
      check("s4_pending_push", 64'(pending), 64'd1);
      step();
      check("s4_pending_pop", 64'(pending), 64'd0);
      check("s4_we", 64'(we), 64'd0);
      check("s4_wdata", 64'(wdata), 64'hFFFF);

      // 5: both FIFOs full, stall mid-drain for two cycles
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_addr = 5'(16 + i); alu_data = 32'h500 + 32'(i);
         lsu_valid = 1'b1; lsu_addr = 5'(20 + i); lsu_data = 32'h600 + 32'(i);
         step();
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      check("s5_pending_sat", 64'(pending), 64'd7);
      check("s5_lsu_full", 64'(lsu_ready), 64'd0);
      n_writes = 0;
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (we) begin n_writes++; wseq.push_back(waddr); end
      end
      rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("s5_stall_we", 64'(we), 64'd0);
      end
      rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (we) begin n_writes++; wseq.push_back(waddr); end
      end
      check("s5_write_count", 64'(n_writes), 64'd8);
      check("s5_first_lsu", 64'(wseq.size() > 0 ? wseq[0] : 5'd31), 64'd20);
      check("s5_second_alu", 64'(wseq.size() > 1 ? wseq[1] : 5'd31), 64'd16);
      check("s5_last_alu", 64'(wseq.size() > 7 ? wseq[7] : 5'd31), 64'd19);
      check("s5_pending_end", 64'(pending), 64'd0);

      // 6: reset with entries pending discards them
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_addr = 5'(24 + i); alu_data = 32'h700 + 32'(i);
         step();
      end
      alu_valid = 1'b0;
      check("s6_pending_before", 64'(pending), 64'd3);
      rst = 1'b1;
      step();
      check("s6_pending", 64'(pending), 64'd0);
      check("s6_we", 64'(we), 64'd0);
      check("s6_alu_ready", 64'(alu_ready), 64'd1);
      check("s6_lsu_ready", 64'(lsu_ready), 64'd1);
      rst = 1'b0; rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("s6_no_stale_we", 64'(we), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
